pulse_period_meter: RTL and testbench

//  Receive end of the tick-pulse scheme: measures the spacing between rising edges of pulse_in.

---
 rtl/pulse_period_meter.sv | 136 +++++++++++++
 tb/tb_pulse_period_meter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pulse_period_meter.sv
// rtl/pulse_period_meter.sv - measures spacing between rising edges of pulse_in in DIV-cycle units
module pulse_period_meter #(
    parameter int DIV = 5000,
    parameter int PW  = 13,
    parameter int CW  = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arm,
    input  logic          pulse_in,
    output logic [CW-1:0] period,
    output logic          valid,
    output logic          ovf,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        MEAS       = 2'd2
    } state_t;

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    // The edge cycle itself is the first clk of the new interval, so the
    // prescaler restarts as if it had already counted that cycle. This makes
    // the captured value floor(spacing / DIV) exactly.
    localparam logic [PW-1:0] PRESC_START = PW'(1);
    localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};

    state_t        state_q, state_d;
    logic          p_q, p_q2;
    logic          rise;
    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sat_q, sat_d;
    logic [CW-1:0] period_q, period_d;
    logic          ovf_q, ovf_d;
    logic          valid_q, valid_d;

    // Two-flop input stage; every edge sees the same one-cycle delay.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q  <= 1'b0;
            p_q2 <= 1'b0;
        end else begin
            p_q  <= pulse_in;
            p_q2 <= p_q;
        end
    end

    assign rise = p_q & ~p_q2;

    // State, prescaler, unit counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            period_q <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            period_q <= period_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    // Next-state logic: arming, first-edge sync, measurement and capture.
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        period_d = period_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;
        busy     = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = WAIT_FIRST;
                end
            end
            WAIT_FIRST: begin
                busy = 1'b1;
                if (!arm) begin
                    state_d = IDLE;
                end else if (rise) begin
                    state_d = MEAS;
                    presc_d = PRESC_START;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            MEAS: begin
                busy = 1'b1;
                if (!arm) begin
                    // Abort wins over a coincident edge: nothing is captured.
                    state_d = IDLE;
                end else if (rise) begin
                    // Edge wins over a coincident prescaler wrap; that
                    // wrap's increment is simply dropped.
                    period_d = cnt_q;
                    ovf_d    = sat_q;
                    valid_d  = 1'b1;
                    presc_d  = PRESC_START;
                    cnt_d    = '0;
                    sat_d    = 1'b0;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (cnt_q == CNT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign period = period_q;
    assign valid  = valid_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// tb/tb_pulse_period_meter.sv - directed self-checking bench for pulse_period_meter
module tb_pulse_period_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm;
    logic        pulse_in;

    logic [12:0] per_a, per_c;
    logic [3:0]  per_b;
    logic        val_a, val_b, val_c;
    logic        ovf_a, ovf_b, ovf_c;
    logic        busy_a, busy_b, busy_c;

    int          sel;
    logic [12:0] per_s;
    logic        val_s, ovf_s, busy_s;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pulse_period_meter #(.DIV(4), .PW(13), .CW(13)) u_div4 (
        .clk(clk), .rst(rst), .arm(arm), .pulse_in(pulse_in),
        .period(per_a), .valid(val_a), .ovf(ovf_a), .busy(busy_a)
    );

    pulse_period_meter #(.DIV(4), .PW(13), .CW(4)) u_div4_cw4 (
        .clk(clk), .rst(rst), .arm(arm), .pulse_in(pulse_in),
        .period(per_b), .valid(val_b), .ovf(ovf_b), .busy(busy_b)
    );

    pulse_period_meter #(.DIV(5000), .PW(13), .CW(13)) u_div5000 (
        .clk(clk), .rst(rst), .arm(arm), .pulse_in(pulse_in),
        .period(per_c), .valid(val_c), .ovf(ovf_c), .busy(busy_c)
    );

    // Route the instance under test to one set of observation signals.
    always_comb begin
        per_s  = per_a;
        val_s  = val_a;
        ovf_s  = ovf_a;
        busy_s = busy_a;
        if (sel == 1) begin
            per_s  = {9'd0, per_b};
            val_s  = val_b;
            ovf_s  = ovf_b;
            busy_s = busy_b;
        end else if (sel == 2) begin
            per_s  = per_c;
            val_s  = val_c;
            ovf_s  = ovf_c;
            busy_s = busy_c;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at the negedge where pulse_in has just risen. Runs s negedges,
    // checking the result of that rising edge (ev/ep/eo), and raises
    // pulse_in again on the s-th negedge when rise_next is set.
    task automatic gap(input int s, input bit rise_next, input bit ev,
                       input logic [12:0] ep, input bit eo);
        for (int i = 1; i <= s; i++) begin
            @(negedge clk);
            if (i == 1) check("edge_cycle_valid", val_s, 1'b0);
            if (i == 2) begin
                check("valid", val_s, ev);
                if (ev) begin
                    check("period", per_s, ep);
                    check("ovf", ovf_s, eo);
                end
            end
            pulse_in = rise_next && (i == s);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; pulse_in = 1'b0; sel = 0;

        // Reset with pulse_in toggling.
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            pulse_in = ~pulse_in;
            @(negedge clk);
            check("rst_period", per_s, 13'd0);
            check("rst_valid", val_s, 1'b0);
            check("rst_ovf", ovf_s, 1'b0);
            check("rst_busy", busy_s, 1'b0);
        end
        rst = 1'b0; pulse_in = 1'b0;
        idle_cycles(3);
        check("idle_busy", busy_s, 1'b0);

        // DIV=4: spacings 40, 40, 7, 3.
        sel = 0;
        arm = 1'b1; pulse_in = 1'b1;
        gap(40, 1, 0, 13'd0, 0);
        gap(40, 1, 1, 13'd10, 0);
        gap(7, 1, 1, 13'd10, 0);
        gap(3, 1, 1, 13'd1, 0);
        gap(10, 0, 1, 13'd0, 0);
        check("meas_busy", busy_s, 1'b1);
        arm = 1'b0;
        idle_cycles(3);
        check("abort_busy", busy_s, 1'b0);

        // DIV=5000: spacings 5000, 5000, 9999, 10000.
        sel = 2;
        arm = 1'b1; pulse_in = 1'b1;
        gap(5000, 1, 0, 13'd0, 0);
        gap(5000, 1, 1, 13'd1, 0);
        gap(9999, 1, 1, 13'd1, 0);
        gap(10000, 1, 1, 13'd1, 0);
        gap(10, 0, 1, 13'd2, 0);
        arm = 1'b0;
        idle_cycles(3);

        // DIV=4, CW=4: saturation at 15 and recovery.
        sel = 1;
        arm = 1'b1; pulse_in = 1'b1;
        gap(100, 1, 0, 13'd0, 0);
        gap(60, 1, 1, 13'd15, 1);
        gap(64, 1, 1, 13'd15, 0);
        gap(20, 1, 1, 13'd15, 1);
        gap(10, 0, 1, 13'd5, 0);
        arm = 1'b0;
        idle_cycles(3);

        // Abort 10 clks after the first edge, edge while idle, re-arm.
        sel = 0;
        arm = 1'b1; pulse_in = 1'b1;
        gap(10, 0, 0, 13'd0, 0);
        arm = 1'b0;
        idle_cycles(2);
        pulse_in = 1'b1;
        gap(6, 0, 0, 13'd0, 0);
        check("abort_period", per_s, 13'd5);
        check("abort_ovf", ovf_s, 1'b0);
        check("abort_idle_busy", busy_s, 1'b0);
        arm = 1'b1; pulse_in = 1'b1;
        gap(16, 1, 0, 13'd0, 0);
        gap(10, 0, 1, 13'd4, 0);

        // Reset mid-measurement, then a pulse held high for 30 clks.
        rst = 1'b1;
        @(negedge clk);
        check("midrst_period", per_s, 13'd0);
        check("midrst_valid", val_s, 1'b0);
        check("midrst_ovf", ovf_s, 1'b0);
        check("midrst_busy", busy_s, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("rearm_busy", busy_s, 1'b1);
        pulse_in = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            check("hold_valid", val_s, 1'b0);
            pulse_in = (i < 30) || (i == 40);
        end
        check("hold_period", per_s, 13'd0);
        gap(10, 0, 1, 13'd10, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
